clock_enable_gen: RTL and testbench
===================================

Name: clock_enable_gen

Overview:
- Parametrised multi-channel successor to the single fixed-ratio divider. It produces one-cycle clock-enable ticks and 50%-duty square strobes from one system clock.
- Each channel has a runtime-programmable divide ratio, a per-channel enable and glitch-free ratio updates.
- A shared Sync input phase-aligns all channels.
- Outputs are enables for downstream logic such as VGA pixel, game-tick and debounce timing. They are not derived clocks.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 27, width of divide ratio and channel counter.
- DEFAULT_DIV, 2, active and shadow divide ratio after reset for every channel.

Ports:
- InputClock  in   1             system clock; all logic on its rising edge only.
- ResetN      in   1             asynchronous, active-low reset.
- DivValue    in   CNT_W         divide-ratio data bus, shared by all channels.
- DivLoad     in   NUM_CH        bit i high for one cycle writes DivValue into channel i shadow register.
- ChEnable    in   NUM_CH        bit i high lets channel i count.
- Sync        in   1             synchronous restart of all channels.
- Tick        out  NUM_CH        registered one-cycle pulse, once per divide period.
- Square      out  NUM_CH        registered; toggles on every tick; period is 2×ratio.
- Pending     out  NUM_CH        shadow ratio differs from active ratio and has not yet been adopted.

Behaviour:
- Clock and reset:
  - Single clock domain, rising edge only.
  - ResetN low asynchronously sets, per channel: cnt=0, act_div=DEFAULT_DIV, shd_div=DEFAULT_DIV, Tick=0, Square=0, Pending=0.
  - Reset asserted mid-period aborts immediately. No partial tick is produced.
- Ratio clamping:
  - Effective ratio is max(DivValue, 1), so DivValue 0 is stored as 1.
  - Ratio is unsigned CNT_W bits. Maximum is 2^CNT_W−1; no overflow is possible.
- DivLoad[i]:
  - Writes the clamped value into shd_div[i].
  - Pending[i] is set the next cycle if shd_div ≠ act_div.
  - It never changes act_div directly.
- Adoption of shd_div into act_div occurs at exactly one of:
  - (a) a terminal-count edge,
  - (b) any edge with ChEnable[i]=0,
  - (c) Sync.
  - Pending[i] clears on the adopting edge.
  - If DivLoad and adoption happen on the same edge, the newly loaded value is adopted.
- Per channel, on each edge, in priority order:
  1. Sync=1: cnt←0, Tick←0, Square←0, act_div←shd_div (or the incoming value if DivLoad coincides).
  2. Else ChEnable[i]=0: cnt holds, Tick←0, Square holds, act_div←shd_div.
  3. Else cnt==act_div−1 (terminal count): cnt←0, Tick←1, Square←~Square, act_div←shd_div.
  4. Else: cnt←cnt+1, Tick←0.
- Timing:
  - Tick rises after the act_div-th consecutive enabled edge counted from cnt=0. It is high for exactly 1 cycle.
  - Spacing between ticks is exactly act_div cycles.
  - Ratio 1: Tick stays high continuously while enabled, and Square toggles every cycle.
  - Square for ratio N: high N cycles, low N cycles.
- Enable gaps: disabling freezes cnt, so the period resumes where it stopped. The period is stretched by the number of disabled cycles.
- Independence: channels are independent except for the shared DivValue bus and Sync.
- Legacy mode: the earlier 100→50 MHz usage is NUM_CH=1, ratio 2, ChEnable=1, using Tick as the enable.

Test Plan:
1. Reset release, DEFAULT_DIV=2, ChEnable=4'b1111 → all Tick high 1 cycle every 2 cycles, first on the 2nd edge; Square toggles on each tick (period 4); Pending=0.
2. Mid-period ratio change: ch0 ratio 5, DivLoad[0] with DivValue=3 when cnt=1 → Pending[0]=1 until the terminal count; ticks spaced 5 cycles, then 3 thereafter; ch1–3 unaffected.
3. DivValue=0 and DivValue=1 on ch2 → both give Tick[2] continuously high and Square[2] toggling every cycle.
4. ch1 ratio 4, ChEnable[1] low for 3 cycles at cnt=2 → Tick[1] 0 throughout the gap; the next tick arrives 2+3 cycles after the gap starts; Square[1] holds.
5. Sync asserted with DivLoad[3] DivValue=6 in the same cycle → all cnt=0, Tick=0, Square=0; ch3 ticks every 6 cycles from the Sync edge; Pending=0.
6. ResetN pulsed low asynchronously between edges with ch0 at ratio 7, cnt=5 → outputs clear immediately, no tick emitted; after release, ratio is 2.

Source files
------------

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divide ratio,
// one-cycle Tick, 50%-duty Square strobe and glitch-free shadowed ratio updates.
module clock_enable_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic              InputClock,
  input  logic              ResetN,
  input  logic [CNT_W-1:0]  DivValue,
  input  logic [NUM_CH-1:0] DivLoad,
  input  logic [NUM_CH-1:0] ChEnable,
  input  logic              Sync,
  output logic [NUM_CH-1:0] Tick,
  output logic [NUM_CH-1:0] Square,
  output logic [NUM_CH-1:0] Pending
);

  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [CNT_W-1:0]  r_act [NUM_CH];
  logic [CNT_W-1:0]  r_shd [NUM_CH];
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] r_square;
  logic [NUM_CH-1:0] r_pend;

  logic [CNT_W-1:0]  w_div;
  logic [CNT_W-1:0]  w_shd_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_term;

  // A ratio of zero would never reach terminal count, so it is stored as one.
  assign w_div = (DivValue == '0) ? CNT_W'(1) : DivValue;

  // Shadow value as it will be after this edge, so a coincident load is adopted.
  // Terminal test uses >= so a ratio shrunk while disabled cannot strand the counter.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_shd_nxt[i] = DivLoad[i] ? w_div : r_shd[i];
      w_term[i]    = (r_cnt[i] >= (r_act[i] - CNT_W'(1)));
    end
  end

  always_ff @(posedge InputClock or negedge ResetN) begin
    if (!ResetN) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
        r_act[i] <= CNT_W'(DEFAULT_DIV);
        r_shd[i] <= CNT_W'(DEFAULT_DIV);
      end
      r_tick   <= '0;
      r_square <= '0;
      r_pend   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_shd[i] <= w_shd_nxt[i];
        if (Sync) begin
          r_cnt[i]    <= '0;
          r_tick[i]   <= 1'b0;
          r_square[i] <= 1'b0;
          r_act[i]    <= w_shd_nxt[i];
          r_pend[i]   <= 1'b0;
        end else if (!ChEnable[i]) begin
          r_tick[i]   <= 1'b0;
          r_act[i]    <= w_shd_nxt[i];
          r_pend[i]   <= 1'b0;
        end else if (w_term[i]) begin
          r_cnt[i]    <= '0;
          r_tick[i]   <= 1'b1;
          r_square[i] <= ~r_square[i];
          r_act[i]    <= w_shd_nxt[i];
          r_pend[i]   <= 1'b0;
        end else begin
          r_cnt[i]    <= r_cnt[i] + CNT_W'(1);
          r_tick[i]   <= 1'b0;
          r_pend[i]   <= (w_shd_nxt[i] != r_act[i]);
        end
      end
    end
  end

  assign Tick    = r_tick;
  assign Square  = r_square;
  assign Pending = r_pend;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: hand-computed Tick/Square/Pending
// values checked one cycle at a time, sampled 1 ns after each rising edge.
module tb_clock_enable_gen;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 27;

  logic              InputClock = 1'b0;
  logic              ResetN;
  logic [CNT_W-1:0]  DivValue;
  logic [NUM_CH-1:0] DivLoad;
  logic [NUM_CH-1:0] ChEnable;
  logic              Sync;
  logic [NUM_CH-1:0] Tick;
  logic [NUM_CH-1:0] Square;
  logic [NUM_CH-1:0] Pending;

  int checks = 0;
  int errors = 0;

  clock_enable_gen #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(2)
  ) dut (
    .InputClock(InputClock),
    .ResetN    (ResetN),
    .DivValue  (DivValue),
    .DivLoad   (DivLoad),
    .ChEnable  (ChEnable),
    .Sync      (Sync),
    .Tick      (Tick),
    .Square    (Square),
    .Pending   (Pending)
  );

  always #5 InputClock = ~InputClock;

  task automatic step();
    @(posedge InputClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetN   = 1'b0;
    DivValue = '0;
    DivLoad  = '0;
    ChEnable = 4'b1111;
    Sync     = 1'b0;
    step(); step();
    chk("rst_tick", Tick, 4'b0000);
    chk("rst_sq",   Square, 4'b0000);
    chk("rst_pend", Pending, 4'b0000);

    // Default ratio 2 on all channels
    ResetN = 1'b1;
    step(); chk("t1_e1_tick", Tick, 4'b0000);
    step(); chk("t1_e2_tick", Tick, 4'b1111); chk("t1_e2_sq", Square, 4'b1111); chk("t1_e2_pend", Pending, 4'b0000);
    step(); chk("t1_e3_tick", Tick, 4'b0000); chk("t1_e3_sq", Square, 4'b1111);
    step(); chk("t1_e4_tick", Tick, 4'b1111); chk("t1_e4_sq", Square, 4'b0000);

    // ch0 ratio 5 (loaded while disabled), then 3 loaded mid-period at cnt=1
    DivValue = 5; DivLoad = 4'b0001; ChEnable = 4'b1110;
    step(); chk("t2_e5_tick", Tick, 4'b0000); chk("t2_e5_pend", Pending, 4'b0000);
    DivLoad = '0; ChEnable = 4'b1111;
    step(); chk("t2_e6_tick", Tick, 4'b1110);
    DivValue = 3; DivLoad = 4'b0001;
    step(); chk("t2_e7_tick", Tick, 4'b0000); chk("t2_e7_pend", Pending, 4'b0001);
    DivLoad = '0;
    step(); chk("t2_e8_tick", Tick, 4'b1110); chk("t2_e8_pend", Pending, 4'b0001);
    step(); chk("t2_e9_tick", Tick, 4'b0000); chk("t2_e9_pend", Pending, 4'b0001);
    step(); chk("t2_e10_tick", Tick, 4'b1111); chk("t2_e10_pend", Pending, 4'b0000); chk("t2_e10_sq", Square, 4'b1111);
    step(); chk("t2_e11_tick", Tick, 4'b0000);
    step(); chk("t2_e12_tick", Tick, 4'b1110);
    step(); chk("t2_e13_tick", Tick, 4'b0001);
    step(); chk("t2_e14_tick", Tick, 4'b1110);
    step(); chk("t2_e15_tick", Tick, 4'b0000);
    step(); chk("t2_e16_tick", Tick, 4'b1111); chk("t2_e16_sq", Square, 4'b0001);

    // ch2 DivValue=0 (clamped to 1), then DivValue=1
    DivValue = 0; DivLoad = 4'b0100;
    step(); chkb("t3_e17_pend2", Pending[2], 1'b1); chkb("t3_e17_tick2", Tick[2], 1'b0);
    DivLoad = '0;
    step(); chkb("t3_e18_tick2", Tick[2], 1'b1); chkb("t3_e18_sq2", Square[2], 1'b1); chkb("t3_e18_pend2", Pending[2], 1'b0);
    step(); chkb("t3_e19_tick2", Tick[2], 1'b1); chkb("t3_e19_sq2", Square[2], 1'b0);
    step(); chkb("t3_e20_tick2", Tick[2], 1'b1); chkb("t3_e20_sq2", Square[2], 1'b1);
    DivValue = 1; DivLoad = 4'b0100;
    step(); chkb("t3_e21_tick2", Tick[2], 1'b1); chkb("t3_e21_sq2", Square[2], 1'b0); chkb("t3_e21_pend2", Pending[2], 1'b0);
    DivLoad = '0;
    step(); chkb("t3_e22_tick2", Tick[2], 1'b1); chkb("t3_e22_sq2", Square[2], 1'b1);

    // ch1 ratio 4, disabled for 3 cycles at cnt=2
    DivValue = 4; DivLoad = 4'b0010; ChEnable = 4'b1101;
    step(); chkb("t4_e23_tick1", Tick[1], 1'b0); chkb("t4_e23_sq1", Square[1], 1'b1); chkb("t4_e23_pend1", Pending[1], 1'b0);
    DivLoad = '0; ChEnable = 4'b1111;
    step(); chkb("t4_e24_tick1", Tick[1], 1'b0);
    step(); chkb("t4_e25_tick1", Tick[1], 1'b0);
    ChEnable = 4'b1101;
    step(); chkb("t4_gap1_tick1", Tick[1], 1'b0); chkb("t4_gap1_sq1", Square[1], 1'b1);
    step(); chkb("t4_gap2_tick1", Tick[1], 1'b0); chkb("t4_gap2_sq1", Square[1], 1'b1);
    step(); chkb("t4_gap3_tick1", Tick[1], 1'b0); chkb("t4_gap3_sq1", Square[1], 1'b1);
    ChEnable = 4'b1111;
    step(); chkb("t4_e29_tick1", Tick[1], 1'b0);
    step(); chkb("t4_e30_tick1", Tick[1], 1'b1); chkb("t4_e30_sq1", Square[1], 1'b0);
    step(); chkb("t4_e31_tick1", Tick[1], 1'b0);

    // Sync with coincident DivLoad[3]=6
    Sync = 1'b1; DivLoad = 4'b1000; DivValue = 6;
    step(); chk("t5_sync_tick", Tick, 4'b0000); chk("t5_sync_sq", Square, 4'b0000); chk("t5_sync_pend", Pending, 4'b0000);
    Sync = 1'b0; DivLoad = '0;
    step(); chk("t5_e33_tick", Tick, 4'b0100);
    step(); chk("t5_e34_tick", Tick, 4'b0100);
    step(); chk("t5_e35_tick", Tick, 4'b0101);
    step(); chk("t5_e36_tick", Tick, 4'b0110);
    step(); chk("t5_e37_tick", Tick, 4'b0100);
    step(); chk("t5_e38_tick", Tick, 4'b1101); chk("t5_e38_pend", Pending, 4'b0000);
    for (int k = 0; k < 5; k++) step();
    chk("t5_e43_tick", Tick, 4'b0100);
    step(); chk("t5_e44_tick", Tick, 4'b1111); chk("t5_e44_sq", Square, 4'b0010);

    // ch0 ratio 7 up to cnt=5, then asynchronous reset between edges
    DivValue = 7; DivLoad = 4'b0001; ChEnable = 4'b1110;
    step(); chkb("t6_load_pend0", Pending[0], 1'b0); chkb("t6_load_tick0", Tick[0], 1'b0);
    DivLoad = '0; ChEnable = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(); chkb("t6_count_tick0", Tick[0], 1'b0);
    end
    #2 ResetN = 1'b0;
    #1;
    chk("t6_arst_tick", Tick, 4'b0000);
    chk("t6_arst_sq", Square, 4'b0000);
    chk("t6_arst_pend", Pending, 4'b0000);
    #2 ResetN = 1'b1;
    step(); chk("t6_rel_e1_tick", Tick, 4'b0000);
    step(); chk("t6_rel_e2_tick", Tick, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
